pipe_stage_reg: RTL

//  Generic, parametrised pipeline-stage register for inter-stage boundaries (EX->MEM, MEM->WB).

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register, valid/ready with halt/flush; optional skid via PIPE_STAGE_SKID_EN
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              accept;
    logic              drain;

    // Halt masks the output side; the control bundle is forced to zero on any bubble
    assign out_valid = main_valid_q & ~halt_sys;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign drain     = out_valid & out_ready;
    assign accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // in_ready depends only on registered state, cutting the out_ready path
    assign in_ready  = ~skid_valid_q & ~halt_sys & ~rst;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // Next-state for main and skid entries
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            // skid full means in_ready is low, so nothing is accepted here
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    // Skid register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`else
    // Single entry: may accept when empty or when the held entry leaves this cycle
    assign in_ready  = (~main_valid_q | out_ready) & ~halt_sys & ~rst;
    assign occupancy = {1'b0, main_valid_q};

    // Next-state for the main entry
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    // Main register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
        end
    end

endmodule
